// File: rtl/bldc_gate_driver.sv
// Three-phase centre-aligned PWM with per-phase dead-time FSM and latched fault shutdown.
// Latency: gate drives are registered, one clk after the edge that changes a phase state.
// Backpressure: none; counter free-runs, shutdown forces phases OFF without stopping the PWM timebase.
module bldc_gate_driver #(
    parameter int DIVIDER  = 1,
    parameter int DEADTIME = 4,
    parameter int INVERT_P = 0,
    parameter int INVERT_N = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       fault,
    input  logic [7:0] pwm_u,
    input  logic [7:0] pwm_v,
    input  logic [7:0] pwm_w,
    output logic       u_p,
    output logic       v_p,
    output logic       w_p,
    output logic       u_n,
    output logic       v_n,
    output logic       w_n,
    output logic       en,
    output logic       fault_latched,
    output logic       sync
);

    localparam int PW = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
    localparam int DW = $clog2(DEADTIME + 1);
    localparam logic [PW-1:0] PRE_MAX = PW'(DIVIDER - 1);
    localparam logic [DW-1:0] DT      = DW'(DEADTIME);
    localparam logic IP = (INVERT_P != 0);
    localparam logic IN = (INVERT_N != 0);

    localparam logic [1:0] ST_OFF  = 2'd0;
    localparam logic [1:0] ST_DEAD = 2'd1;
    localparam logic [1:0] ST_HIGH = 2'd2;
    localparam logic [1:0] ST_LOW  = 2'd3;

    logic [PW-1:0]       pre_q, pre_d;
    logic                tick;
    logic [7:0]          cnt_q, cnt_d;
    logic                up_q, up_d;
    logic                valley;
    logic                sync_q, sync_d;
    logic [2:0][7:0]     shd_q, shd_d;
    logic [2:0]          raw;
    logic [2:0]          raw_q, raw_d;
    logic [2:0][1:0]     st_q, st_d;
    logic [2:0][DW-1:0]  dcnt_q, dcnt_d;
    logic [2:0]          p_q, p_d;
    logic [2:0]          n_q, n_d;
    logic                flt_q, flt_d;
    logic                en_q, en_d;
    logic                halt;

    always_comb begin
        tick   = (pre_q == PRE_MAX);
        pre_d  = tick ? '0 : pre_q + 1'b1;
        cnt_d  = cnt_q;
        up_d   = up_q;
        valley = 1'b0;
        if (tick) begin
            if (up_q) begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == 8'd254) up_d = 1'b0;
            end else begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q == 8'd1) begin
                    up_d   = 1'b1;
                    valley = 1'b1;
                end
            end
        end
        // Duties only take effect at the valley so a mid-period write cannot glitch a pulse.
        sync_d = valley;
        shd_d  = valley ? {pwm_w, pwm_v, pwm_u} : shd_q;
    end

    assign halt = ~enable | flt_q | fault;

    always_comb begin
        flt_d = fault | (enable & flt_q);
        en_d  = enable & ~flt_q & ~fault;
    end

    always_comb begin
        raw    = '0;
        st_d   = st_q;
        dcnt_d = dcnt_q;
        p_d    = '0;
        n_d    = '0;
        for (int i = 0; i < 3; i++) begin
            raw[i] = (shd_q[i] > cnt_q);
            if (halt) begin
                st_d[i]   = ST_OFF;
                dcnt_d[i] = DT;
            end else begin
                case (st_q[i])
                    ST_OFF: begin
                        st_d[i]   = ST_DEAD;
                        dcnt_d[i] = DT;
                    end
                    ST_DEAD: begin
                        // A raw edge inside the gap restarts the full dead time.
                        if (raw[i] != raw_q[i]) begin
                            dcnt_d[i] = DT;
                        end else if (dcnt_q[i] <= DW'(1)) begin
                            st_d[i] = raw[i] ? ST_HIGH : ST_LOW;
                        end else begin
                            dcnt_d[i] = dcnt_q[i] - 1'b1;
                        end
                    end
                    ST_HIGH: begin
                        if (!raw[i]) begin
                            st_d[i]   = ST_DEAD;
                            dcnt_d[i] = DT;
                        end
                    end
                    ST_LOW: begin
                        if (raw[i]) begin
                            st_d[i]   = ST_DEAD;
                            dcnt_d[i] = DT;
                        end
                    end
                    default: begin
                        st_d[i]   = ST_OFF;
                        dcnt_d[i] = DT;
                    end
                endcase
            end
            p_d[i] = (st_d[i] == ST_HIGH);
            n_d[i] = (st_d[i] == ST_LOW);
        end
        raw_d = raw;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q  <= '0;
            cnt_q  <= '0;
            up_q   <= 1'b1;
            sync_q <= 1'b0;
            shd_q  <= '0;
            raw_q  <= '0;
            st_q   <= {3{ST_OFF}};
            dcnt_q <= {3{DT}};
            p_q    <= '0;
            n_q    <= '0;
            flt_q  <= 1'b0;
            en_q   <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            cnt_q  <= cnt_d;
            up_q   <= up_d;
            sync_q <= sync_d;
            shd_q  <= shd_d;
            raw_q  <= raw_d;
            st_q   <= st_d;
            dcnt_q <= dcnt_d;
            p_q    <= p_d;
            n_q    <= n_d;
            flt_q  <= flt_d;
            en_q   <= en_d;
        end
    end

    assign u_p           = p_q[0] ^ IP;
    assign v_p           = p_q[1] ^ IP;
    assign w_p           = p_q[2] ^ IP;
    assign u_n           = n_q[0] ^ IN;
    assign v_n           = n_q[1] ^ IN;
    assign w_n           = n_q[2] ^ IN;
    assign en            = en_q;
    assign fault_latched = flt_q;
    assign sync          = sync_q;

endmodule

// File: tb/tb_bldc_gate_driver.sv
// Bench for bldc_gate_driver: per-period pulse-width table, shutdown/fault/reset sequences, overlap monitor.
module tb_bldc_gate_driver;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       fault = 1'b0;
    logic [7:0] pwm_u = 8'd0;
    logic [7:0] pwm_v = 8'd0;
    logic [7:0] pwm_w = 8'd0;
    logic       u_p, v_p, w_p, u_n, v_n, w_n, en, fault_latched, sync;

    bldc_gate_driver #(.DIVIDER(1), .DEADTIME(4), .INVERT_P(0), .INVERT_N(0)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .fault(fault),
        .pwm_u(pwm_u), .pwm_v(pwm_v), .pwm_w(pwm_w),
        .u_p(u_p), .v_p(v_p), .w_p(w_p), .u_n(u_n), .v_n(v_n), .w_n(w_n),
        .en(en), .fault_latched(fault_latched), .sync(sync)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] du, dv, dw;
        int up, un, vp, vn, wp, wn;
    } vec_t;

    typedef struct {
        int up, un, vp, vn, wp, wn, len;
    } meas_t;

    int   checks = 0;
    int   fails  = 0;
    bit   mon_en = 1'b0;
    vec_t vecs[4];
    vec_t exp_q[$];
    int   last_drv[3];
    int   gap[3];

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    task automatic check_all_off(input string name);
        chk(name, int'({u_p, u_n, v_p, v_n, w_p, w_n}), 0);
    endtask

    task automatic wait_sync(input int limit, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sync && n < limit);
        if (!sync) chk("sync_timeout", 0, 1);
    endtask

    // Counts active cycles per drive from the current sync cycle up to (excluding) the next one.
    task automatic measure(input int chg_at, input logic [7:0] chg_val, output meas_t m);
        m = '{default: 0};
        do begin
            m.up += int'(u_p); m.un += int'(u_n);
            m.vp += int'(v_p); m.vn += int'(v_n);
            m.wp += int'(w_p); m.wn += int'(w_n);
            m.len++;
            if (chg_at != 0 && m.len == chg_at) pwm_u = chg_val;
            @(negedge clk);
        end while (!sync && m.len < 1000);
        if (!sync) chk("period_timeout", 0, 1);
    endtask

    task automatic startup_dead(input string name);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_all_off(name);
        end
        @(negedge clk);
        chk({name, "_v_n"}, int'(v_n), 1);
    endtask

    // Overlap and dead-gap monitor on every phase.
    always @(negedge clk) begin
        if (mon_en) begin
            logic [2:0] pv, nv;
            pv = {w_p, v_p, u_p};
            nv = {w_n, v_n, u_n};
            for (int i = 0; i < 3; i++) begin
                chk("p_n_overlap", int'(pv[i] & nv[i]), 0);
                if (pv[i] | nv[i]) begin
                    int cur;
                    cur = pv[i] ? 1 : 2;
                    if (last_drv[i] != 0 && last_drv[i] != cur) chk("dead_gap_short", int'(gap[i] >= 4), 1);
                    last_drv[i] = cur;
                    gap[i] = 0;
                end else begin
                    gap[i]++;
                end
            end
        end
    end

    initial begin
        int    n;
        meas_t m;
        vec_t  e;

        vecs[0] = '{8'd128, 8'd0,   8'd255, 251, 251, 0,   510, 505, 0};
        vecs[1] = '{8'd64,  8'd200, 8'd10,  123, 379, 395, 107, 15,  487};
        vecs[2] = '{8'd1,   8'd128, 8'd0,   0,   505, 251, 251, 0,   510};
        vecs[3] = '{8'd255, 8'd64,  8'd200, 505, 0,   123, 379, 395, 107};
        for (int i = 0; i < 3; i++) begin
            last_drv[i] = 0;
            gap[i] = 0;
        end

        repeat (3) @(negedge clk);
        check_all_off("reset_gates");
        chk("reset_en", int'(en), 0);
        chk("reset_fault_latched", int'(fault_latched), 0);
        chk("reset_sync", int'(sync), 0);

        rst_n  = 1'b1;
        mon_en = 1'b1;
        enable = 1'b1;
        @(negedge clk);
        check_all_off("startup_dead");
        chk("startup_en", int'(en), 1);
        repeat (3) begin
            @(negedge clk);
            check_all_off("startup_dead");
        end
        @(negedge clk);
        chk("startup_low_sides", int'({u_n, v_n, w_n}), 7);
        wait_sync(600, n);
        chk("first_sync_cycle", 5 + n, 510);

        for (int i = 0; i < 4; i++) begin
            pwm_u = vecs[i].du;
            pwm_v = vecs[i].dv;
            pwm_w = vecs[i].dw;
            exp_q.push_back(vecs[i]);
            wait_sync(600, n);
            wait_sync(600, n);
            measure(0, 8'd0, m);
            e = exp_q.pop_front();
            chk("tbl_u_p", m.up, e.up);
            chk("tbl_u_n", m.un, e.un);
            chk("tbl_v_p", m.vp, e.vp);
            chk("tbl_v_n", m.vn, e.vn);
            chk("tbl_w_p", m.wp, e.wp);
            chk("tbl_w_n", m.wn, e.wn);
            chk("tbl_period", m.len, 510);
        end

        // Duty write mid-period must not show until the following valley.
        pwm_u = 8'd128; pwm_v = 8'd0; pwm_w = 8'd0;
        wait_sync(600, n);
        wait_sync(600, n);
        measure(100, 8'd32, m);
        chk("upd_old_duty_u_p", m.up, 251);
        measure(0, 8'd0, m);
        chk("upd_new_duty_u_p", m.up, 59);
        chk("upd_period", m.len, 510);

        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!u_p && n < 600);
        chk("u_p_high_seen", int'(u_p), 1);
        enable = 1'b0;
        @(negedge clk);
        check_all_off("disable_off");
        chk("disable_en", int'(en), 0);
        repeat (3) @(negedge clk);
        enable = 1'b1;
        startup_dead("reenable_dead");

        fault = 1'b1;
        @(negedge clk);
        fault = 1'b0;
        chk("fault_latch_set", int'(fault_latched), 1);
        chk("fault_en", int'(en), 0);
        @(negedge clk);
        check_all_off("fault_off");
        repeat (5) @(negedge clk);
        chk("fault_latch_held", int'(fault_latched), 1);
        check_all_off("fault_held_off");
        enable = 1'b0;
        fault  = 1'b1;
        @(negedge clk);
        chk("fault_wins", int'(fault_latched), 1);
        fault = 1'b0;
        @(negedge clk);
        chk("fault_clear", int'(fault_latched), 0);
        enable = 1'b1;
        startup_dead("fault_resume");
        chk("fault_resume_en", int'(en), 1);

        #2 rst_n = 1'b0;
        #1;
        check_all_off("async_reset_gates");
        chk("async_reset_en", int'(en), 0);
        @(negedge clk);
        rst_n = 1'b1;
        startup_dead("post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
